// File: rtl/deser_queue_ctrl_if.sv
// Bundle of the producer, consumer and queue-side signals of deser_queue_ctrl.
// The slave modport is the controller's view. The master modport is the environment's view:
// deserializer, byte queue and output stage together.
interface deser_queue_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       data_in;
    logic             data_valid_in;
    logic             ack_out;
    logic             deq_req_in;
    logic [7:0]       data_out;
    logic             data_valid_out;
    logic [7:0]       q_data_out;
    logic             q_enq_out;
    logic             q_deq_out;
    logic [7:0]       q_data_in;
    logic [CNT_W-1:0] q_len_in;
    logic [CNT_W-1:0] count_out;
    logic             err_out;

    modport master (
        output data_in, data_valid_in, deq_req_in, q_data_in, q_len_in,
        input  ack_out, data_out, data_valid_out, q_data_out, q_enq_out, q_deq_out,
               count_out, err_out
    );

    modport slave (
        input  data_in, data_valid_in, deq_req_in, q_data_in, q_len_in,
        output ack_out, data_out, data_valid_out, q_data_out, q_enq_out, q_deq_out,
               count_out, err_out
    );
endinterface

// File: rtl/deser_queue_ctrl.sv
// deser_queue_ctrl: sequencer/arbiter between the deserializer, an 8-entry byte queue and
// the byte consumer. It issues one enq or deq pulse at a time and tracks occupancy privately.
// Optional feature macro: FAIR_RR_EN (round-robin arbitration on conflict; default ENQ wins).

// Runtime properties of the controller outputs.
module deser_queue_ctrl_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             enq,
    input logic             deq,
    input logic             ack,
    input logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // A simultaneous enq and deq would lose the queue's length update.
    a_no_enq_deq: assert property (@(posedge clk) disable iff (rst) !(enq && deq));
    // Occupancy can never exceed the queue capacity.
    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
    // The producer is acknowledged exactly when a byte is written to the queue.
    a_ack_is_enq: assert property (@(posedge clk) disable iff (rst) ack == enq);
endmodule

module deser_queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic              clock_10,
    input logic              reset,
    deser_queue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENQ  = 2'd1,
        ST_DEQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
`ifdef FAIR_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif
    // last_grant encoding: 1 = ENQ was granted last, 0 = DEQ was granted last
    localparam logic GRANT_ENQ = 1'b1;
    localparam logic GRANT_DEQ = 1'b0;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             last_grant_r, last_grant_s;
    logic             ack_r, ack_s;
    logic             enq_r, enq_s;
    logic             deq_r, deq_s;
    logic [7:0]       q_data_r, q_data_s;
    logic [7:0]       data_out_r, data_out_s;
    logic             dv_r, dv_s;
    logic             err_r, err_s;
    logic             can_enq_s, can_deq_s, grant_enq_s;

    // Request qualification and conflict resolution for the IDLE decision.
    always_comb begin
        can_enq_s = bus.data_valid_in && (count_r < DEPTH_C);
        can_deq_s = bus.deq_req_in && (count_r != ZERO_C);
        if (can_enq_s && can_deq_s) begin
            grant_enq_s = RR_EN ? (last_grant_r == GRANT_DEQ) : 1'b1;
        end else begin
            grant_enq_s = can_enq_s;
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        last_grant_s = last_grant_r;
        ack_s        = 1'b0;
        enq_s        = 1'b0;
        deq_s        = 1'b0;
        q_data_s     = q_data_r;
        data_out_s   = data_out_r;
        dv_s         = 1'b0;
        err_s        = err_r;
        case (state_r)
            ST_IDLE: begin
                // The queue's len has settled only while idle.
                err_s = err_r | (bus.q_len_in != count_r);
                if (grant_enq_s) begin
                    state_s      = ST_ENQ;
                    q_data_s     = bus.data_in;
                    enq_s        = 1'b1;
                    ack_s        = 1'b1;
                    count_s      = count_r + ONE_C;
                    last_grant_s = GRANT_ENQ;
                end else if (can_deq_s) begin
                    state_s      = ST_DEQ;
                    deq_s        = 1'b1;
                    count_s      = count_r - ONE_C;
                    last_grant_s = GRANT_DEQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ENQ: begin
                state_s = ST_IDLE;
            end
            ST_DEQ: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // The queue registered the byte at the end of DEQ.
                data_out_s = bus.q_data_in;
                dv_s       = 1'b1;
                state_s    = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, occupancy and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock_10 or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= ZERO_C;
            last_grant_r <= GRANT_DEQ;
            ack_r        <= 1'b0;
            enq_r        <= 1'b0;
            deq_r        <= 1'b0;
            q_data_r     <= 8'h00;
            data_out_r   <= 8'h00;
            dv_r         <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            last_grant_r <= last_grant_s;
            ack_r        <= ack_s;
            enq_r        <= enq_s;
            deq_r        <= deq_s;
            q_data_r     <= q_data_s;
            data_out_r   <= data_out_s;
            dv_r         <= dv_s;
            err_r        <= err_s;
        end
    end

    assign bus.ack_out        = ack_r;
    assign bus.q_enq_out      = enq_r;
    assign bus.q_deq_out      = deq_r;
    assign bus.q_data_out     = q_data_r;
    assign bus.data_out       = data_out_r;
    assign bus.data_valid_out = dv_r;
    assign bus.count_out      = count_r;
    assign bus.err_out        = err_r;

    deser_queue_ctrl_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clock_10),
        .rst   (reset),
        .enq   (enq_r),
        .deq   (deq_r),
        .ack   (ack_r),
        .count (count_r)
    );
endmodule
